berzerk_input_cond: RTL and testbench
=====================================

BERZERK_INPUT_COND -- requirements
Module: berzerk_input_cond

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 40000, is the number of consecutive stable clk_sys cycles required to accept a level change (1 ms at 40 MHz); legal range 1..65535.
REQ-002: Parameter COIN_FRAMES, default 3, is the coin pulse length in frames; legal range 1..15.
REQ-003: Parameter AUTOFIRE_FRAMES, default 4, is the autofire half-period in frames; legal range 1..15.
REQ-004: clk_sys  in  1  system clock (40 MHz); the only clock.
REQ-005: reset  in  1  synchronous, active-high reset, sampled on the rising clk_sys edge.
REQ-006: joy_in  in  8  raw merged player controls {coin, start2, start1, fire, up, down, left, right}, bit 7..0; asynchronous to clk_sys.
REQ-007: vblank  in  1  core vertical blank; each rising edge is one frame tick.
REQ-008: autofire_ena  in  1  OSD autofire enable; static between frames.
REQ-009: right, left, down, up, fire, start1, start2, coin  out  1 each  conditioned controls to the game core; registered.

Function
REQ-010: Each joy_in bit SHALL pass through a 2-flop synchronizer; vblank SHALL pass through its own 2-flop synchronizer plus an edge-detect flop.
REQ-011: Each bit SHALL have an independent 16-bit stability counter that clears whenever the synchronized bit equals the debounced state or differs from the previous synchronized value.
REQ-012: The debounced state of a bit SHALL take the new level when its counter reaches DEBOUNCE_CYCLES-1 while the synchronized bit still differs; the counter then clears.
REQ-013: A clean level change on joy_in SHALL appear on the corresponding output exactly DEBOUNCE_CYCLES+3 cycles later (2 sync, DEBOUNCE_CYCLES debounce, 1 output register).
REQ-014: A pulse on a joy_in bit shorter than DEBOUNCE_CYCLES cycles at the synchronizer output SHALL never reach the output.
REQ-015: Opposing directions SHALL be neutralised: if debounced up and down are both 1, both up and down outputs SHALL be 0; the same rule applies to left and right.
REQ-016: start1, start2, right, left, down and up SHALL be the registered debounced levels after REQ-015.
REQ-017: The coin state machine SHALL have states IDLE, PULSE and WAIT_REL.
REQ-018: In IDLE, a 0->1 transition of debounced coin SHALL move to PULSE, assert coin on the following cycle, and clear the 4-bit frame counter.
REQ-019: In PULSE, coin SHALL stay 1; the frame counter SHALL increment on each frame tick; when it reaches COIN_FRAMES, coin SHALL drop to 0 and the FSM SHALL go to WAIT_REL (or to IDLE if debounced coin is already 0).
REQ-020: In WAIT_REL, coin SHALL stay 0 until debounced coin is 0, then the FSM SHALL return to IDLE; holding coin SHALL therefore credit exactly once.
REQ-021: A release and re-press of coin during PULSE SHALL neither extend nor retrigger the pulse.
REQ-022: If no frame tick occurs, PULSE SHALL persist until one does; there is no timeout.

Reset
REQ-023: While reset is 1, all synchronizers, debounced states, counters and outputs SHALL be 0, and the coin FSM SHALL be in IDLE.
REQ-024: A reset asserted mid-debounce or mid-pulse SHALL abort it; after reset, inputs already held at 1 SHALL be re-accepted per REQ-013, and a held coin SHALL generate a new pulse.

Configuration
REQ-025: Macro BERZERK_AUTOFIRE_EN: when defined, if autofire_ena=1 and debounced fire=1, the fire output SHALL start at 1 and toggle every AUTOFIRE_FRAMES frame ticks; releasing fire or clearing autofire_ena SHALL force fire to follow the debounced fire level and reset the autofire counter.
REQ-026: Without BERZERK_AUTOFIRE_EN, autofire_ena SHALL be ignored, no autofire logic SHALL be synthesized, and fire SHALL equal the registered debounced fire.

Verification (DEBOUNCE_CYCLES=4, COIN_FRAMES=3, AUTOFIRE_FRAMES=2)
REQ-027: Set joy_in[3]=1 at cycle 0 and hold it -> up=1 first at cycle 7; clear it -> up=0 exactly 7 cycles later.
REQ-028: Apply a 3-cycle pulse on joy_in[0] -> right stays 0 throughout.
REQ-029: Hold joy_in=8'h0C (up+down) -> up=0 and down=0; then drop bit 2 -> up=1 after 7 cycles.
REQ-030: Hold coin high across 10 frames -> coin=1 for exactly 3 frame ticks, then 0 until release; release and re-press -> one new 3-frame pulse.
REQ-031: Assert reset during a coin pulse with coin held -> coin=0 during reset; a new 3-frame pulse starts after debounce.
REQ-032: With BERZERK_AUTOFIRE_EN defined, autofire_ena=1 and fire held for 8 frames -> fire pattern 1,1,0,0,1,1,0,0 per frame; without the macro -> fire=1 constant.

Source files
------------

// File: rtl/berzerk_input_cond.sv
// Berzerk control conditioning: sync, debounce, opposing-direction lockout, one-shot coin pulse.
// Optional autofire on the fire button when BERZERK_AUTOFIRE_EN is defined.
module berzerk_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 40000,
    parameter int unsigned COIN_FRAMES     = 3,
    parameter int unsigned AUTOFIRE_FRAMES = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] joy_in,
    input  logic       vblank,
    input  logic       autofire_ena,
    output logic       right,
    output logic       left,
    output logic       down,
    output logic       up,
    output logic       fire,
    output logic       start1,
    output logic       start2,
    output logic       coin
);

    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  COIN_END = 4'(COIN_FRAMES);

    typedef enum logic [1:0] {
        C_IDLE,
        C_PULSE,
        C_WAIT_REL
    } coin_state_t;

    logic [7:0]  joy_s1_q, joy_s2_q, joy_prev_q;
    logic [7:0]  deb_q, deb_d;
    logic [15:0] cnt_q [8];
    logic [15:0] cnt_d [8];
    logic        vb_s1_q, vb_s2_q, vb_s3_q;
    logic        frame_tick;
    logic [6:0]  out_q, out_d;
    logic        coin_prev_q;
    logic        coin_q, coin_d;
    coin_state_t state_q, state_d;
    logic [3:0]  frm_cnt_q, frm_cnt_d;
    logic        fire_d;

    assign frame_tick = vb_s2_q & ~vb_s3_q;

    // A bit's counter only runs while the synchronized level is different from the
    // debounced level and unchanged since last cycle; acceptance uses the next count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = 16'd0;
            if ((joy_s2_q[i] != deb_q[i]) && (joy_s2_q[i] == joy_prev_q[i])) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
            if ((joy_s2_q[i] != deb_q[i]) && (cnt_d[i] == DB_LAST)) begin
                deb_d[i] = joy_s2_q[i];
                cnt_d[i] = 16'd0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        frm_cnt_d = frm_cnt_q;
        case (state_q)
            C_IDLE: begin
                if (deb_q[7] && !coin_prev_q) begin
                    state_d   = C_PULSE;
                    frm_cnt_d = 4'd0;
                end
            end
            C_PULSE: begin
                if (frame_tick) begin
                    frm_cnt_d = frm_cnt_q + 4'd1;
                    if (frm_cnt_d == COIN_END) begin
                        state_d = deb_q[7] ? C_WAIT_REL : C_IDLE;
                    end
                end
            end
            C_WAIT_REL: begin
                if (!deb_q[7]) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
        coin_d = (state_d == C_PULSE);
    end

`ifdef BERZERK_AUTOFIRE_EN
    localparam logic [3:0] AF_END = 4'(AUTOFIRE_FRAMES);

    logic       af_on;
    logic [3:0] af_cnt_q, af_cnt_d;
    logic       af_phase_q, af_phase_d;

    assign af_on = autofire_ena & deb_q[4];

    // Phase idles high so an engaged burst always begins with fire asserted.
    always_comb begin
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (!af_on) begin
            af_cnt_d   = 4'd0;
            af_phase_d = 1'b1;
        end else if (frame_tick) begin
            af_cnt_d = af_cnt_q + 4'd1;
            if (af_cnt_d == AF_END) begin
                af_cnt_d   = 4'd0;
                af_phase_d = ~af_phase_q;
            end
        end
        fire_d = af_on ? af_phase_d : deb_q[4];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_q   <= 4'd0;
            af_phase_q <= 1'b1;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end
`else
    logic [4:0] unused_cfg;
    assign unused_cfg = {autofire_ena, 4'(AUTOFIRE_FRAMES)};
    assign fire_d     = deb_q[4];
`endif

    always_comb begin
        out_d    = 7'd0;
        out_d[0] = deb_q[0] & ~deb_q[1];
        out_d[1] = deb_q[1] & ~deb_q[0];
        out_d[2] = deb_q[2] & ~deb_q[3];
        out_d[3] = deb_q[3] & ~deb_q[2];
        out_d[4] = fire_d;
        out_d[5] = deb_q[5];
        out_d[6] = deb_q[6];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_s1_q    <= 8'd0;
            joy_s2_q    <= 8'd0;
            joy_prev_q  <= 8'd0;
            deb_q       <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 16'd0;
            end
            vb_s1_q     <= 1'b0;
            vb_s2_q     <= 1'b0;
            vb_s3_q     <= 1'b0;
            out_q       <= 7'd0;
            coin_prev_q <= 1'b0;
            coin_q      <= 1'b0;
            state_q     <= C_IDLE;
            frm_cnt_q   <= 4'd0;
        end else begin
            joy_s1_q    <= joy_in;
            joy_s2_q    <= joy_s1_q;
            joy_prev_q  <= joy_s2_q;
            deb_q       <= deb_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            vb_s1_q     <= vblank;
            vb_s2_q     <= vb_s1_q;
            vb_s3_q     <= vb_s2_q;
            out_q       <= out_d;
            coin_prev_q <= deb_q[7];
            coin_q      <= coin_d;
            state_q     <= state_d;
            frm_cnt_q   <= frm_cnt_d;
        end
    end

    assign right  = out_q[0];
    assign left   = out_q[1];
    assign down   = out_q[2];
    assign up     = out_q[3];
    assign fire   = out_q[4];
    assign start1 = out_q[5];
    assign start2 = out_q[6];
    assign coin   = coin_q;

endmodule

// File: tb/tb_berzerk_input_cond.sv
// Directed bench for berzerk_input_cond with DEBOUNCE_CYCLES=4, COIN_FRAMES=3, AUTOFIRE_FRAMES=2.
module tb_berzerk_input_cond;

    logic       clk_sys;
    logic       reset;
    logic [7:0] joy_in;
    logic       vblank;
    logic       autofire_ena;
    logic       right, left, down, up, fire, start1, start2, coin;
    logic [7:0] outv;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] joy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];
    logic af_exp [8];

    berzerk_input_cond #(
        .DEBOUNCE_CYCLES (4),
        .COIN_FRAMES     (3),
        .AUTOFIRE_FRAMES (2)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .joy_in       (joy_in),
        .vblank       (vblank),
        .autofire_ena (autofire_ena),
        .right        (right),
        .left         (left),
        .down         (down),
        .up           (up),
        .fire         (fire),
        .start1       (start1),
        .start2       (start2),
        .coin         (coin)
    );

    assign outv = {coin, start2, start1, fire, up, down, left, right};

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Cycles until output bit idx first equals val; -1 when the bound expires.
    task automatic first_at(input int idx, input logic val, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_sys);
            #1;
            if (outv[idx] == val) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic frame();
        vblank = 1'b1;
        cycles(4);
        vblank = 1'b0;
        cycles(4);
    endtask

    // Runs n frames with coin held; returns the tick on which coin fell and re-rise count.
    task automatic coin_frames(input int n, output int drop, output int rerise);
        drop   = 0;
        rerise = 0;
        for (int f = 1; f <= n; f++) begin
            frame();
            if (!coin && drop == 0) drop = f;
            else if (coin && drop != 0) rerise++;
        end
    endtask

    initial begin
        int cyc, hits, drop, rerise;

        vecs[0]  = '{"idle",         8'h00, 8'h00};
        vecs[1]  = '{"right",        8'h01, 8'h01};
        vecs[2]  = '{"left_right",   8'h03, 8'h00};
        vecs[3]  = '{"left",         8'h02, 8'h02};
        vecs[4]  = '{"up_down",      8'h0C, 8'h00};
        vecs[5]  = '{"up",           8'h08, 8'h08};
        vecs[6]  = '{"down",         8'h04, 8'h04};
        vecs[7]  = '{"fire",         8'h10, 8'h10};
        vecs[8]  = '{"start1",       8'h20, 8'h20};
        vecs[9]  = '{"start2",       8'h40, 8'h40};
        vecs[10] = '{"mix",          8'h65, 8'h65};
        vecs[11] = '{"all_dirs",     8'h3F, 8'h30};
`ifdef BERZERK_AUTOFIRE_EN
        af_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        af_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

        reset        = 1'b1;
        joy_in       = 8'hFF;
        vblank       = 1'b0;
        autofire_ena = 1'b0;
        cycles(6);
        check("reset_outputs", int'(outv), 0);
        joy_in = 8'h00;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check("idle_after_reset", int'(outv), 0);

        joy_in = 8'h08;
        first_at(3, 1'b1, cyc);
        check("up_rise_latency", cyc, 7);
        joy_in = 8'h00;
        first_at(3, 1'b0, cyc);
        check("up_fall_latency", cyc, 7);

        hits   = 0;
        joy_in = 8'h01;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk_sys);
            #1;
            if (right) hits++;
            if (k == 3) joy_in = 8'h00;
        end
        check("short_pulse_blocked", hits, 0);

        joy_in = 8'h0C;
        cycles(10);
        check("up_down_up", int'(up), 0);
        check("up_down_down", int'(down), 0);
        joy_in = 8'h08;
        first_at(3, 1'b1, cyc);
        check("up_after_down_release", cyc, 7);

        for (int i = 0; i < 12; i++) begin
            joy_in = vecs[i].joy;
            cycles(10);
            check(vecs[i].name, int'(outv), int'(vecs[i].exp));
        end

        joy_in = 8'h00;
        cycles(12);
        joy_in = 8'h80;
        first_at(7, 1'b1, cyc);
        check("coin_rise_latency", cyc, 7);
        coin_frames(10, drop, rerise);
        check("coin_pulse_ticks", drop, 3);
        check("coin_no_retrigger_held", rerise, 0);
        joy_in = 8'h00;
        cycles(12);
        check("coin_released", int'(coin), 0);
        joy_in = 8'h80;
        first_at(7, 1'b1, cyc);
        check("coin_repress_latency", cyc, 7);
        coin_frames(5, drop, rerise);
        check("coin_repress_ticks", drop, 3);
        check("coin_repress_single", rerise, 0);

        joy_in = 8'h00;
        cycles(12);
        joy_in = 8'h80;
        first_at(7, 1'b1, cyc);
        check("coin_pre_reset_rise", cyc, 7);
        frame();
        check("coin_mid_pulse", int'(coin), 1);
        reset = 1'b1;
        cycles(1);
        check("coin_in_reset", int'(coin), 0);
        cycles(2);
        check("outs_in_reset", int'(outv), 0);
        reset = 1'b0;
        first_at(7, 1'b1, cyc);
        check("coin_after_reset_latency", cyc, 7);
        coin_frames(5, drop, rerise);
        check("coin_after_reset_ticks", drop, 3);

        joy_in = 8'h00;
        cycles(12);
        autofire_ena = 1'b1;
        joy_in       = 8'h10;
        cycles(10);
        for (int f = 0; f < 8; f++) begin
            if (f > 0) frame();
            check($sformatf("autofire_frame%0d", f), int'(fire), int'(af_exp[f]));
        end
        joy_in = 8'h00;
        cycles(10);
        check("autofire_release", int'(fire), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
